// File: rtl/adder64_pipe_ctrl.sv
// Two-stage valid/ready pipeline around a combinational 64-bit adder.
// Supports ADD, SUB, ACC and LOAD ops and keeps a running accumulator.

module adder64 #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         c0,
    output logic [W-1:0] S,
    output logic         c64
);
    assign {c64, S} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, c0};
endmodule

module adder64_pipe_ctrl #(
    parameter int unsigned   W        = 64,
    parameter logic [W-1:0]  ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         c0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         c64,
    output logic         ovf,
    output logic         zero,
    output logic [W-1:0] acc
);
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic         s1_valid;
    logic         s2_valid;
    op_e          op1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         c01;

    logic         adv1;
    logic         adv2;
    logic         accept;

    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf_next;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = s1_valid && adv2;
    assign in_ready  = !s1_valid || adv2;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            op1      <= OP_ADD;
            a1       <= '0;
            b1       <= '0;
            c01      <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            op1      <= op_e'(op);
            a1       <= A;
            b1       <= B;
            c01      <= c0;
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    // Operand select feeding the adder; SUB is A + ~B + 1, LOAD passes A through.
    always_comb begin
        a_in = a1;
        b_in = b1;
        c_in = c01;
        case (op1)
            OP_SUB: begin
                b_in = ~b1;
                c_in = 1'b1;
            end
            OP_ACC: begin
                a_in = acc;
                b_in = a1;
            end
            OP_LOAD: begin
                b_in = '0;
                c_in = 1'b0;
            end
            default: begin
                a_in = a1;
            end
        endcase
    end

    adder64 #(.W(W)) u_adder (
        .A   (a_in),
        .B   (b_in),
        .c0  (c_in),
        .S   (sum),
        .c64 (carry)
    );

    assign ovf_next = (a_in[W-1] == b_in[W-1]) && (sum[W-1] != a_in[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            S        <= '0;
            c64      <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (adv1) begin
            s2_valid <= 1'b1;
            S        <= sum;
            c64      <= carry;
            ovf      <= ovf_next;
            zero     <= (sum == '0);
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Written at the adv1 edge so the next ACC beat in stage 1 sees it without a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_INIT;
        end else if (adv1 && (op1 == OP_ACC || op1 == OP_LOAD)) begin
            acc <= sum;
        end
    end
endmodule

// File: tb/tb_adder64_pipe_ctrl.sv
// Directed self-checking bench for adder64_pipe_ctrl: op arithmetic, flags,
// accumulator chaining, backpressure and asynchronous reset.

module tb_adder64_pipe_ctrl;
    localparam logic [63:0] TB_ACC_INIT = 64'h0000_0000_0000_1234;
    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_ACC  = 2'b10;
    localparam logic [1:0]  OP_LOAD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        c0 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] S;
    logic        c64;
    logic        ovf;
    logic        zero;
    logic [63:0] acc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder64_pipe_ctrl #(.W(64), .ACC_INIT(TB_ACC_INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .c0        (c0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c64       (c64),
        .ovf       (ovf),
        .zero      (zero),
        .acc       (acc)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (S !== 64'h0) begin n_fail++; $display("FAIL reset_S: got %h want 0", S); end
        n_checks++; if (c64 !== 1'b0) begin n_fail++; $display("FAIL reset_c64: got %b want 0", c64); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
        n_checks++; if (acc !== TB_ACC_INIT) begin n_fail++; $display("FAIL reset_acc: got %h want %h", acc, TB_ACC_INIT); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    endtask

    // One beat into an empty pipe; result must appear exactly two edges after it is driven.
    task automatic test_single_beat(input string name, input logic [1:0] o, input logic [63:0] a,
                                    input logic [63:0] b, input logic c, input logic [63:0] es,
                                    input logic ec, input logic eo, input logic ez);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o; A = a; B = b; c0 = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
        n_checks++; if (S !== es) begin n_fail++; $display("FAIL %s_S: got %h want %h", name, S, es); end
        n_checks++; if (c64 !== ec) begin n_fail++; $display("FAIL %s_c64: got %b want %b", name, c64, ec); end
        n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", name, ovf, eo); end
        n_checks++; if (zero !== ez) begin n_fail++; $display("FAIL %s_zero: got %b want %b", name, zero, ez); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain: got %b want 0", name, out_valid); end
    endtask

    task automatic test_acc_chain();
        logic [1:0]  ops [4];
        logic [63:0] av [4];
        logic [63:0] exp_s [4];
        int got;
        ops = '{OP_LOAD, OP_ACC, OP_ACC, OP_ACC};
        av = '{64'd10, 64'd3, 64'd4, 64'd5};
        exp_s = '{64'd10, 64'd13, 64'd17, 64'd22};
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
            if (cyc < 4) begin
                in_valid = 1'b1;
                op = ops[cyc];
                A  = av[cyc];
                B  = 64'hFFFF_0000_DEAD_BEEF;
                c0 = (cyc == 0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                n_checks++; if (S !== exp_s[got]) begin n_fail++; $display("FAIL acc_chain_S%0d: got %0d want %0d", got, S, exp_s[got]); end
                n_checks++; if (cyc !== got + 2) begin n_fail++; $display("FAIL acc_chain_timing%0d: cycle %0d want %0d", got, cyc, got + 2); end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL acc_chain_count: got %0d want 4", got); end
        n_checks++; if (acc !== 64'd22) begin n_fail++; $display("FAIL acc_chain_final: got %0d want 22", acc); end
        test_single_beat("add_keeps_acc", OP_ADD, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (acc !== 64'd22) begin n_fail++; $display("FAIL acc_hold_after_add: got %0d want 22", acc); end
        test_single_beat("sub_keeps_acc", OP_SUB, 64'd9, 64'd1, 1'b0, 64'd8, 1'b1, 1'b0, 1'b0);
        n_checks++; if (acc !== 64'd22) begin n_fail++; $display("FAIL acc_hold_after_sub: got %0d want 22", acc); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_s [8];
        logic        exp_ir;
        int sent;
        int recv;
        for (int i = 0; i < 8; i++) exp_s[i] = 64'(i) * 64'h0101_0101_0101_0101 + 64'(i + 1);
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            exp_ir = !(cyc >= 3 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                op = OP_ADD;
                A  = 64'(sent) * 64'h0101_0101_0101_0101;
                B  = 64'(sent + 1);
                c0 = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, exp_ir); end
            if (cyc >= 3 && cyc <= 6) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid_c%0d: got %b want 1", cyc, out_valid); end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                n_checks++; if (S !== exp_s[recv]) begin n_fail++; $display("FAIL bp_S%0d_c%0d: got %h want %h", recv, cyc, S, exp_s[recv]); end
                if (out_ready) recv++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (sent !== 8) begin n_fail++; $display("FAIL bp_sent: got %0d want 8", sent); end
        n_checks++; if (recv !== 8) begin n_fail++; $display("FAIL bp_recv: got %0d want 8", recv); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid = 1'b1;
            op = (cyc == 0) ? OP_LOAD : OP_ADD;
            A  = (cyc == 0) ? 64'h55 : 64'd1;
            B  = 64'd1;
            c0 = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        n_checks++; if (acc !== 64'h55) begin n_fail++; $display("FAIL mid_pre_acc: got %h want 55", acc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        n_checks++; if (acc !== TB_ACC_INIT) begin n_fail++; $display("FAIL mid_async_acc: got %h want %h", acc, TB_ACC_INIT); end
        n_checks++; if (S !== 64'h0) begin n_fail++; $display("FAIL mid_async_S: got %h want 0", S); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_c%0d: got %b want 0", cyc, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        test_single_beat("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        test_single_beat("add_neg_ovf", OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        test_single_beat("add_cin", OP_ADD, 64'd1, 64'd2, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0);
        test_single_beat("sub_borrow", OP_SUB, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        test_single_beat("sub_noborrow", OP_SUB, 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
        test_acc_chain();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
